// File: rtl/apb_pwm_array.sv
// apb_pwm_array: APB-programmable array of NUM_CH PWM channels sharing one
// prescaler + timebase. Each channel shadows its DUTY/COUNT at activation and
// at every timebase wrap, and can stop itself after COUNT periods.
// Optional feature macro: APB_PWM_ARRAY_IRQ_EN (IEN register + level irq_o).

// Per-channel slice: activation, shadows, pulse counter and registered output.
module apb_pwm_array_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_en,      // next-cycle CTRL bit for this channel
  input  logic             i_run,     // timebase currently running
  input  logic             i_wrap,    // timebase wraps on this edge
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_duty,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_done,
  output logic             o_pwm
);
  logic             r_active;
  logic             r_pwm;
  logic [CNT_W-1:0] r_duty_sh;
  logic [CNT_W-1:0] r_count_sh;
  logic [CNT_W-1:0] r_pc;
  logic [CNT_W-1:0] w_pc_inc;
  logic             w_act;

  assign w_pc_inc = r_pc + CNT_W'(1);
  // Last pulse of a counted burst completes on this wrap.
  assign o_done   = r_active & i_wrap & (r_count_sh != '0) & (w_pc_inc == r_count_sh);
  // Armed channel goes live at the next wrap, or at once if the timebase is idle.
  assign w_act    = i_en & ~r_active & (i_wrap | ~i_run);
  assign o_pwm    = r_pwm;

  // Channel state: deactivate on disable/done, activate when armed, count wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_active   <= 1'b0;
      r_pwm      <= 1'b0;
      r_duty_sh  <= '0;
      r_count_sh <= '0;
      r_pc       <= '0;
    end else begin
      r_pwm <= r_active & i_en & ~o_done & (i_cnt < r_duty_sh);
      if (!i_en || o_done) begin
        r_active <= 1'b0;
        r_pc     <= '0;
      end else if (w_act) begin
        r_active <= 1'b1;
        r_pc     <= '0;
      end else if (r_active && i_wrap) begin
        r_pc <= w_pc_inc;
      end
      if (w_act || i_wrap) begin
        r_duty_sh  <= i_duty;
        r_count_sh <= i_count;
      end
    end
  end
endmodule

module apb_pwm_array #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [7:0]        paddr_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              irq_o
);
  logic                          r_pready;
  logic [NUM_CH-1:0]             r_ctrl;
  logic [NUM_CH-1:0]             r_status;
  logic [15:0]                   r_presc;
  logic [15:0]                   r_presc_act;
  logic [15:0]                   r_pcnt;
  logic [CNT_W-1:0]              r_period;
  logic [CNT_W-1:0]              r_period_act;
  logic [CNT_W-1:0]              r_cnt;
  logic [NUM_CH-1:0][CNT_W-1:0]  r_duty;
  logic [NUM_CH-1:0][CNT_W-1:0]  r_count;

  logic [NUM_CH-1:0]             w_done;
  logic [NUM_CH-1:0]             w_pwm;
  logic [NUM_CH-1:0]             w_ctrl_nxt;
  logic                          w_run;
  logic                          w_tick;
  logic                          w_wrap;
  logic                          w_err;
  logic                          w_wr;
  logic [31:0]                   w_rdata;
  logic                          w_sel_ctrl;
  logic                          w_sel_presc;
  logic                          w_sel_period;
  logic                          w_sel_status;
  logic [NUM_CH-1:0]             w_sel_duty;
  logic [NUM_CH-1:0]             w_sel_count;
  logic                          w_in_win;
  logic [2:0]                    w_slot;
  logic                          w_unused;

`ifdef APB_PWM_ARRAY_IRQ_EN
  logic [NUM_CH-1:0]             r_ien;
  logic                          r_irq;
  logic                          w_sel_ien;
`endif

  // Bits of pwdata_i above the widest field are ignored by design.
  assign w_unused = ^pwdata_i;

  // Channel window 0x20..0x5F: two words per slot (DUTY, COUNT).
  assign w_in_win = (paddr_i >= 8'h20) && (paddr_i < 8'h60) && (paddr_i[1:0] == 2'b00);
  assign w_slot   = 3'(paddr_i[6:3] - 4'd4);

  // Address decode and read mux; anything unmatched is a slave error.
  always_comb begin
    w_err        = 1'b1;
    w_rdata      = '0;
    w_sel_ctrl   = 1'b0;
    w_sel_presc  = 1'b0;
    w_sel_period = 1'b0;
    w_sel_status = 1'b0;
    w_sel_duty   = '0;
    w_sel_count  = '0;
`ifdef APB_PWM_ARRAY_IRQ_EN
    w_sel_ien    = 1'b0;
`endif
    case (paddr_i)
      8'h00: begin w_err = 1'b0; w_sel_ctrl   = 1'b1; w_rdata = 32'(r_ctrl);   end
      8'h04: begin w_err = 1'b0; w_sel_presc  = 1'b1; w_rdata = 32'(r_presc);  end
      8'h08: begin w_err = 1'b0; w_sel_period = 1'b1; w_rdata = 32'(r_period); end
      8'h0C: begin w_err = 1'b0; w_sel_status = 1'b1; w_rdata = 32'(r_status); end
      8'h10: begin
        w_err = 1'b0;
`ifdef APB_PWM_ARRAY_IRQ_EN
        w_sel_ien = 1'b1;
        w_rdata   = 32'(r_ien);
`endif
      end
      default: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (w_in_win && (w_slot == 3'(c))) begin
            w_err = 1'b0;
            if (!paddr_i[2]) begin
              w_sel_duty[c] = 1'b1;
              w_rdata       = 32'(r_duty[c]);
            end else begin
              w_sel_count[c] = 1'b1;
              w_rdata        = 32'(r_count[c]);
            end
          end
        end
      end
    endcase
  end

  // Write strobe on the edge that closes the ready cycle.
  assign w_wr = r_pready & psel_i & penable_i & pwrite_i & ~w_err;

  // A bus CTRL write overrides any auto-clear landing on the same edge.
  assign w_ctrl_nxt = (w_wr && w_sel_ctrl) ? pwdata_i[NUM_CH-1:0] : (r_ctrl & ~w_done);

  assign pready_o  = r_pready & ~rst_i;
  assign pslverr_o = r_pready & w_err & ~rst_i;
  assign prdata_o  = (r_pready && !rst_i) ? w_rdata : 32'h0;
  assign pwm_o     = w_pwm & {NUM_CH{~rst_i}};

  // One wait state: ready follows the first access-phase cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_pready <= 1'b0;
    else       r_pready <= psel_i & penable_i & ~r_pready;
  end

  // Configuration and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl   <= '0;
      r_presc  <= '0;
      r_period <= '1;
      r_duty   <= '0;
      r_count  <= '0;
      r_status <= '0;
    end else begin
      r_ctrl <= w_ctrl_nxt;
      if (w_wr && w_sel_presc)  r_presc  <= pwdata_i[15:0];
      if (w_wr && w_sel_period) r_period <= pwdata_i[CNT_W-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr && w_sel_duty[c])  r_duty[c]  <= pwdata_i[CNT_W-1:0];
        if (w_wr && w_sel_count[c]) r_count[c] <= pwdata_i[CNT_W-1:0];
        // Done-set beats a simultaneous write-1-to-clear.
        if (w_done[c])                              r_status[c] <= 1'b1;
        else if (w_wr && w_sel_status && pwdata_i[c]) r_status[c] <= 1'b0;
      end
    end
  end

  assign w_run  = |r_ctrl;
  assign w_tick = w_run & (r_pcnt == r_presc_act);
  assign w_wrap = w_tick & (r_cnt == r_period_act);

  // Shared prescaler + timebase; PRESC/PERIOD only take hold at a wrap or while idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pcnt       <= '0;
      r_cnt        <= '0;
      r_presc_act  <= '0;
      r_period_act <= '1;
    end else if (!w_run) begin
      r_pcnt       <= '0;
      r_cnt        <= '0;
      r_presc_act  <= r_presc;
      r_period_act <= r_period;
    end else begin
      r_pcnt <= w_tick ? 16'h0 : r_pcnt + 16'h1;
      if (w_tick) r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      if (w_wrap) begin
        r_presc_act  <= r_presc;
        r_period_act <= r_period;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
    apb_pwm_array_ch #(.CNT_W(CNT_W)) u_ch (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_en    (w_ctrl_nxt[c]),
      .i_run   (w_run),
      .i_wrap  (w_wrap),
      .i_cnt   (r_cnt),
      .i_duty  (r_duty[c]),
      .i_count (r_count[c]),
      .o_done  (w_done[c]),
      .o_pwm   (w_pwm[c])
    );
  end

`ifdef APB_PWM_ARRAY_IRQ_EN
  // Interrupt enables and registered level interrupt.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ien <= '0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr && w_sel_ien) r_ien <= pwdata_i[NUM_CH-1:0];
      r_irq <= |(r_status & r_ien);
    end
  end
  assign irq_o = r_irq & ~rst_i;
`else
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_apb_pwm_array.sv
// Directed bench for apb_pwm_array (NUM_CH=4, CNT_W=16). APB read/write
// expectations go through a scoreboard queue; PWM waveforms are measured as
// run lengths at negedge sample points.
module tb_apb_pwm_array;
  localparam int NUM_CH = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              psel_i, penable_i, pwrite_i;
  logic [7:0]        paddr_i;
  logic [31:0]       pwdata_i;
  logic [31:0]       prdata_o;
  logic              pready_o, pslverr_o;
  logic [NUM_CH-1:0] pwm_o;
  logic              irq_o;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
    bit          chk_data;
  } exp_t;

  exp_t sb[$];
  int   n_chk, n_fail;
  int   h1, l1, h2, l2, n;

  apb_pwm_array #(.NUM_CH(NUM_CH), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .pwm_o(pwm_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_chk++;
    n_fail++;
    $error("FAIL %s: timed out waiting for DUT", tag);
  endtask

  task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    int   k;
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = a; pwdata_i = d;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    k = 0;
    do begin @(negedge clk_i); k++; end while (!pready_o && k < 8);
    e = sb.pop_front();
    if (!pready_o) bound_fail({e.tag, "_pready"});
    else begin
      chk({e.tag, "_err"}, 32'(pslverr_o), 32'(e.err));
      if (e.chk_data) chk(e.tag, prdata_o, e.data);
    end
    @(posedge clk_i); #1;
    chk({e.tag, "_pulse1"}, 32'(pready_o), 32'd0);
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    sb.push_back('{tag: "wr", data: 32'h0, err: 1'b0, chk_data: 1'b0});
    apb(1'b1, a, d);
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp, input logic err);
    sb.push_back('{tag: tag, data: exp, err: err, chk_data: 1'b1});
    apb(1'b0, a, 32'h0);
  endtask

  task automatic wait_lvl(input int ch, input logic lvl);
    int k = 0;
    while (pwm_o[ch] !== lvl && k < 400) begin @(negedge clk_i); k++; end
    if (k >= 400) bound_fail("wait_pwm_level");
  endtask

  // Leaves the caller at the negedge where pwm_o[ch] is first seen high.
  task automatic sync_rise(input int ch);
    @(negedge clk_i);
    wait_lvl(ch, 1'b0);
    wait_lvl(ch, 1'b1);
  endtask

  task automatic run_len(input int ch, input logic lvl, output int len);
    len = 0;
    while (pwm_o[ch] === lvl && len < 400) begin len++; @(negedge clk_i); end
  endtask

  task automatic count_hi(input int ch, input int cyc, output int cnt);
    cnt = 0;
    repeat (cyc) begin @(negedge clk_i); if (pwm_o[ch]) cnt++; end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_outs", 32'({irq_o, pslverr_o, pready_o, pwm_o}), 32'd0);
    chk("rst_prdata", prdata_o, 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    // Reset values
    rd("ctrl_rst",   8'h00, 32'h0,    1'b0);
    rd("presc_rst",  8'h04, 32'h0,    1'b0);
    rd("period_rst", 8'h08, 32'hFFFF, 1'b0);
    rd("status_rst", 8'h0C, 32'h0,    1'b0);
    rd("duty0_rst",  8'h20, 32'h0,    1'b0);
    rd("count3_rst", 8'h3C, 32'h0,    1'b0);

    // Field widths: upper write bits dropped
    wr(8'h08, 32'hABCD_0009);
    rd("period_w", 8'h08, 32'h9, 1'b0);
    wr(8'h20, 32'hFFFF_0003);
    rd("duty0_w", 8'h20, 32'h3, 1'b0);

    // Basic waveform: 3 high / 7 low
    wr(8'h00, 32'h1);
    sync_rise(0);
    run_len(0, 1'b1, h1); run_len(0, 1'b0, l1);
    run_len(0, 1'b1, h2); run_len(0, 1'b0, l2);
    chk("wave_hi1", 32'(h1), 32'd3); chk("wave_lo1", 32'(l1), 32'd7);
    chk("wave_hi2", 32'(h2), 32'd3); chk("wave_lo2", 32'(l2), 32'd7);

    // Shadowing: DUTY 3->8 written in the middle of a period
    sync_rise(0);
    fork
      begin
        run_len(0, 1'b1, h1); run_len(0, 1'b0, l1);
        run_len(0, 1'b1, h2); run_len(0, 1'b0, l2);
      end
      wr(8'h20, 32'd8);
    join
    chk("shadow_hi_cur", 32'(h1), 32'd3); chk("shadow_lo_cur", 32'(l1), 32'd7);
    chk("shadow_hi_nxt", 32'(h2), 32'd8); chk("shadow_lo_nxt", 32'(l2), 32'd2);

    // Extremes
    wr(8'h20, 32'd0);
    repeat (25) @(posedge clk_i);
    count_hi(0, 20, n);
    chk("duty0_const_low", 32'(n), 32'd0);
    wr(8'h20, 32'd10);
    repeat (25) @(posedge clk_i);
    count_hi(0, 20, n);
    chk("duty_full_const_high", 32'(n), 32'd20);
    wr(8'h20, 32'd3);
    wr(8'h04, 32'h1234_0002);
    rd("presc_w", 8'h04, 32'h2, 1'b0);
    repeat (40) @(posedge clk_i);
    sync_rise(0);
    run_len(0, 1'b1, h1); run_len(0, 1'b0, l1);
    chk("presc2_hi", 32'(h1), 32'd9); chk("presc2_lo", 32'(l1), 32'd21);
    wr(8'h00, 32'h0);
    wr(8'h04, 32'h0);

    // Pulse count: two pulses on channel 1 then auto-stop
`ifdef APB_PWM_ARRAY_IRQ_EN
    wr(8'h10, 32'h2);
    rd("ien_rw", 8'h10, 32'h2, 1'b0);
`else
    wr(8'h10, 32'h3);
    rd("ien_absent", 8'h10, 32'h0, 1'b0);
`endif
    wr(8'h2C, 32'd2);
    wr(8'h28, 32'd5);
    wr(8'h00, 32'h2);
    begin
      int   rises, highs;
      logic prev;
      rises = 0; highs = 0; prev = pwm_o[1];
      repeat (60) begin
        @(negedge clk_i);
        if (pwm_o[1]) highs++;
        if (pwm_o[1] && !prev) rises++;
        prev = pwm_o[1];
      end
      chk("count_pulses", 32'(rises), 32'd2);
      chk("count_high_clks", 32'(highs), 32'd10);
    end
    rd("count_ctrl_clr", 8'h00, 32'h0, 1'b0);
    rd("count_status", 8'h0C, 32'h2, 1'b0);
    @(negedge clk_i);
    chk("count_pwm1_low", 32'(pwm_o[1]), 32'd0);
`ifdef APB_PWM_ARRAY_IRQ_EN
    chk("irq_set", 32'(irq_o), 32'd1);
`else
    chk("irq_tied", 32'(irq_o), 32'd0);
`endif

    // Slave errors
    rd("bad_0x60",  8'h60, 32'h0, 1'b1);
    rd("bad_slot4", 8'h40, 32'h0, 1'b1);
    rd("bad_0x14",  8'h14, 32'h0, 1'b1);
    rd("bad_unal",  8'h21, 32'h0, 1'b1);

    // STATUS W1C landing on the same edge as channel 0's done-set
    wr(8'h24, 32'd1);
    wr(8'h00, 32'h1);
    repeat (6) @(posedge clk_i);
    wr(8'h0C, 32'h3);
    rd("w1c_vs_set", 8'h0C, 32'h1, 1'b0);
    rd("w1c_ctrl", 8'h00, 32'h0, 1'b0);

    // Reset mid-period with every channel running, and mid-transfer
    wr(8'h24, 32'd0);
    wr(8'h2C, 32'd0);
    wr(8'h30, 32'd2);
    wr(8'h38, 32'd10);
    wr(8'h00, 32'hF);
    repeat (15) @(posedge clk_i);
    @(negedge clk_i);
    chk("pre_rst_pwm3", 32'(pwm_o[3]), 32'd1);
    @(posedge clk_i); #1;
    psel_i = 1'b1; pwrite_i = 1'b1; paddr_i = 8'h20; pwdata_i = 32'h55;
    @(posedge clk_i); #1;
    penable_i = 1'b1; rst_i = 1'b1;
    @(negedge clk_i);
    chk("in_rst_outs", 32'({irq_o, pslverr_o, pready_o, pwm_o}), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_outs", 32'({irq_o, pslverr_o, pready_o, pwm_o}), 32'd0);
    rd("post_ctrl",   8'h00, 32'h0,    1'b0);
    rd("post_period", 8'h08, 32'hFFFF, 1'b0);
    rd("post_status", 8'h0C, 32'h0,    1'b0);
    rd("post_duty0",  8'h20, 32'h0,    1'b0);
    rd("post_duty3",  8'h38, 32'h0,    1'b0);
    rd("post_count0", 8'h24, 32'h0,    1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_pwm_array.md
APB_PWM_ARRAY -- requirements
Module: apb_pwm_array

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of PWM channels (legal range 1..8).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the period, duty and pulse-count fields (legal range 8..16).
REQ-003 The block SHALL have port clk_i, input, width 1: the single clock.
REQ-004 The block SHALL have port rst_i, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have APB inputs psel_i, penable_i and pwrite_i (1 bit each), paddr_i [7:0] and pwdata_i [31:0].
REQ-006 The block SHALL have APB outputs prdata_o [31:0], pready_o (1 bit) and pslverr_o (1 bit).
REQ-007 The block SHALL have output pwm_o [NUM_CH-1:0], one registered PWM output per channel.
REQ-008 The block SHALL have output irq_o, width 1: the level interrupt.

Function
REQ-009 The register map SHALL be: 0x00 CTRL (bits [NUM_CH-1:0] enable, RW); 0x04 PRESC (RW, 16 bits); 0x08 PERIOD (RW, CNT_W bits); 0x0C STATUS (done bits, write-1-to-clear); 0x10 IEN; 0x20+8*ch DUTY; 0x24+8*ch COUNT.
REQ-010 For any access, pready_o SHALL pulse high for exactly one cycle: the cycle after the first cycle with psel_i&penable_i high and pready_o low (one wait state).
REQ-011 Writes SHALL commit on the clock edge that ends the pready_o cycle; prdata_o SHALL be valid only while pready_o is high and SHALL be 0 otherwise.
REQ-012 Unmapped addresses, and channel slots at or above NUM_CH, SHALL assert pslverr_o together with pready_o, return prdata_o = 0 and change no state.
REQ-013 Prescaler: a tick SHALL occur every PRESC+1 clocks; PRESC = 0 gives a tick every clock.
REQ-014 Timebase: a shared counter SHALL count 0..PERIOD on ticks and then wrap to 0, so the period is PERIOD+1 ticks.
REQ-015 Timebase: the counter SHALL run while any CTRL enable bit is set, and the prescaler and counter SHALL be held at 0 while all enable bits are clear.
REQ-016 A newly enabled channel SHALL be armed and SHALL become active at the next wrap, or immediately if the timebase was idle; its output SHALL stay low until it is active.
REQ-017 DUTY and COUNT SHALL be shadowed; a channel's shadows SHALL load at activation and at every wrap, so mid-period writes never glitch the output.
REQ-018 Output: pwm_o[ch] SHALL be registered (one clock latency) and high iff the channel is active and counter < duty_shadow.
REQ-019 Output edge cases: duty 0 SHALL give constant low; duty >= PERIOD+1 SHALL give constant high.
REQ-020 Pulse count: COUNT = 0 SHALL mean continuous operation; otherwise a per-channel counter SHALL increment at each wrap while the channel is active.
REQ-021 When the pulse counter reaches COUNT, the channel SHALL clear its CTRL bit, set STATUS[ch], drive its output low and reset its counter to 0.
REQ-022 If an APB CTRL write and an auto-clear occur in the same cycle, the APB write SHALL win.
REQ-023 If a STATUS write-1-to-clear and a done-set occur in the same cycle, the set SHALL win.
REQ-024 A CTRL write clearing a bit mid-period SHALL deactivate that channel at once: output low next cycle, pulse counter reset, STATUS unchanged.
REQ-025 A PERIOD or PRESC write SHALL take effect at the next wrap; the current period SHALL complete at the old value.
REQ-026 Field widths SHALL be: DUTY, COUNT and PERIOD hold CNT_W bits; upper write bits are ignored and read back as 0.
REQ-027 All counters SHALL wrap modulo their width and SHALL never saturate.

Reset
REQ-028 On rst_i high at a clock edge, all registers SHALL clear: CTRL=0, PRESC=0, PERIOD=all-ones, DUTY=0, COUNT=0, STATUS=0, IEN=0, shadows=0, counters=0.
REQ-029 During reset, pwm_o, prdata_o, pready_o, pslverr_o and irq_o SHALL all be 0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no pready_o pulse and no register write.

Configuration
REQ-031 With macro APB_PWM_ARRAY_IRQ_EN defined, IEN SHALL be RW and irq_o SHALL be registered, equal to |(STATUS & IEN).
REQ-032 Without APB_PWM_ARRAY_IRQ_EN, 0x10 SHALL read 0, writes to it SHALL be ignored without pslverr_o, and irq_o SHALL be tied to 0.

Verification
REQ-033 Waveform: PRESC=0, PERIOD=9, DUTY0=3, CTRL=1 -> pwm_o[0] is 3 clocks high and 7 clocks low, repeating with period 10.
REQ-034 Pulse count: COUNT1=2, DUTY1=5, CTRL=2 -> exactly 2 pulses, then CTRL[1]=0, STATUS[1]=1, pwm_o[1] held low; with the macro and IEN[1]=1, irq_o=1.
REQ-035 Shadowing: mid-period DUTY0 write 3 -> 8 -> the current period keeps 3 high clocks and the next period has 8.
REQ-036 Extremes: DUTY=0 -> constant low; DUTY=PERIOD+1 -> constant high; PRESC=2 -> every phase is 3x longer.
REQ-037 APB: read 0x60 -> pslverr_o=1, prdata_o=0; a STATUS write of 1 on the same cycle as a done-set -> STATUS bit stays 1.
REQ-038 Reset: rst_i pulsed mid-period with all channels active -> the next cycle all outputs are 0 and readback matches the REQ-028 values.
